mem_access: RTL
===============

# mem_access

Memory-access pipeline stage of the RISC-V core: consumes the EX/MEM register outputs and feeds the writeback stage through the `wd`/`wreg`/`wdata` triple. Non-memory instructions pass straight through. Loads and stores run a single-master request/acknowledge transaction on the data bus under a small FSM, stalling the pipeline until completion. Loads are byte-lane extracted and sign- or zero-extended before writeback.

## Interface
- `TIMEOUT`, default 255: bus-wait limit in BUSY cycles; used only when `MEM_TIMEOUT_EN` is defined.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `wd_i` in 5: destination register index from EX/MEM.
- `wreg_i` in 1: register write enable from EX/MEM.
- `wdata_i` in 32: ALU result from EX/MEM.
- `memop_i` in 4: 0000 none, 0001 LB, 0010 LH, 0011 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; other codes are treated as none.
- `mem_addr_i` in 32: effective byte address.
- `mem_sdata_i` in 32: store data, right-aligned.
- `dbus_req_o` out 1: bus request.
- `dbus_we_o` out 1: 1 = store.
- `dbus_addr_o` out 32: word address, `{mem_addr_i[31:2],2'b00}`.
- `dbus_sel_o` out 4: byte-lane enables, little-endian.
- `dbus_wdata_o` out 32: store data replicated into the selected lanes.
- `dbus_rdata_i` in 32: read data, valid with ack.
- `dbus_ack_i` in 1: single-cycle transfer-complete acknowledge.
- `stall_req_o` out 1: freezes the pipeline; EX/MEM inputs are held stable while high.
- `wd_o` out 5, `wreg_o` out 1, `wdata_o` out 32: to writeback.
- `err_o` out 1: one-cycle pulse on a misaligned access or bus timeout.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE, no memory op:** `wd_o`/`wreg_o`/`wdata_o` follow the inputs combinationally. `stall_req_o=0`.
- **IDLE, aligned memory op:**
  - `stall_req_o=1` combinationally.
  - Register addr, we, sel and wdata into the bus output registers.
  - Next state is BUSY. `wreg_o=0` this cycle.
- **IDLE, misaligned op:**
  - Misaligned means halfword with `addr[0]=1`, or word with `addr[1:0]≠0`.
  - `err_o=1`, `wreg_o=0`, no stall, no bus access. Remain in IDLE.
- **BUSY:**
  - `dbus_req_o=1`; bus outputs held constant. `stall_req_o=1`, `wreg_o=0`.
  - On `dbus_ack_i`: capture `dbus_rdata_i` and go to DONE.
- **DONE:**
  - `stall_req_o=0`. `wd_o=wd_i`.
  - Load: `wreg_o=wreg_i`, `wdata_o` = extracted load data.
  - Store: `wreg_o=0`.
  - Next state is IDLE unconditionally.
- **Lane selection:**
  - Byte: `sel=0001<<addr[1:0]`, `wdata={4{sdata[7:0]}}`.
  - Half: `sel=0011<<addr[1:0]`, `wdata={2{sdata[15:0]}}`.
  - Word: `sel=1111`.
- **Load extraction:** shift the captured word right by `8*addr[1:0]`, take the low 8/16/32 bits. LB/LH sign-extend; LBU/LHU zero-extend.
- `dbus_ack_i` is ignored outside BUSY.
- Reset asserted mid-transaction: `dbus_req_o` drops immediately (asynchronously), FSM returns to IDLE, and the transaction is abandoned.
- **Reset values:** `dbus_req_o=0`, `dbus_we_o=0`, `dbus_addr_o=0`, `dbus_sel_o=0`, `dbus_wdata_o=0`, `stall_req_o=0`, `wd_o=0`, `wreg_o=0`, `wdata_o=0`, `err_o=0`. All outputs are forced to 0 while `rst=1`.

## Timing
- Non-memory op: 0-cycle pass-through.
- Memory op with ack in cycle k of BUSY (k≥1): the stage occupies 2+k cycles (IDLE, k BUSY cycles, DONE). `stall_req_o` is high for 1+k cycles.
  - Minimum is 3 cycles with 2 stall cycles.
- A new instruction may be accepted in the IDLE cycle immediately after DONE. Back-to-back memory ops therefore have no gap beyond this.
- `err_o` is a single-cycle pulse: in IDLE for misalignment, in DONE for timeout.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT` without ack, the FSM goes to DONE with `err_o=1`, `wreg_o=0` and `wdata_o=0`, and `dbus_req_o` drops.
  - If ack arrives in the same cycle the limit is reached, ack wins (normal completion, no error).
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely for ack; `TIMEOUT` is unused.

## Test plan
- ADD-type pass-through: `memop=0`, `wd=5`, `wreg=1`, `wdata=0x1234` -> same cycle `wd_o=5`, `wreg_o=1`, `wdata_o=0x1234`, `stall_req_o=0`.
- LB at `addr=0x1003`, ack on the first BUSY cycle with `rdata=0x80FFFFFF` -> `sel=1000`, `dbus_addr_o=0x1000`, 2 stall cycles, DONE `wdata_o=0xFFFFFF80`. The same access with LBU -> `wdata_o=0x00000080`.
- SH at `addr=0x2002`, `sdata=0xABCD1234`, ack after 3 BUSY cycles -> `we=1`, `sel=1100`, `wdata_o(bus)=0x12341234`, `wreg_o=0` throughout, 4 stall cycles.
- LW at `addr=0x3001` -> `err_o` pulses in that cycle, `dbus_req_o` stays 0, `wreg_o=0`, no stall.
- With `MEM_TIMEOUT_EN` and `TIMEOUT=4`, LW with no ack -> `dbus_req_o` high for 4 cycles, then DONE with `err_o=1`, `wreg_o=0`. Repeat with ack on the 4th BUSY cycle -> normal completion, `err_o=0`.
- Assert `rst` in the second BUSY cycle of a load -> `dbus_req_o` and `stall_req_o` fall without waiting for a clock edge. After release the FSM is in IDLE, and a late ack is ignored.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: RISC-V MEM stage. Runs request/ack data-bus transactions for loads and stores
// and passes other ops through. Optional bus-wait timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        stall_req_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        to_q, to_d;

  logic        is_load_s, is_store_s, is_unsigned_s, is_mem_s, misaligned_s;
  logic [1:0]  size_s;
  logic [3:0]  lane_sel_s;
  logic [31:0] lane_wdata_s;
  logic [31:0] shifted_s, load_s;
  logic        stall_s, wreg_s, err_s, limit_s;
  logic [31:0] wdata_s;

  // Decode memop into direction, access size (0 byte, 1 half, 2 word) and signedness
  always_comb begin
    is_load_s     = 1'b0;
    is_store_s    = 1'b0;
    is_unsigned_s = 1'b0;
    size_s        = 2'd0;
    case (memop_i)
      4'b0001: begin is_load_s = 1'b1; size_s = 2'd0; end
      4'b0010: begin is_load_s = 1'b1; size_s = 2'd1; end
      4'b0011: begin is_load_s = 1'b1; size_s = 2'd2; end
      4'b0100: begin is_load_s = 1'b1; size_s = 2'd0; is_unsigned_s = 1'b1; end
      4'b0101: begin is_load_s = 1'b1; size_s = 2'd1; is_unsigned_s = 1'b1; end
      4'b1000: begin is_store_s = 1'b1; size_s = 2'd0; end
      4'b1001: begin is_store_s = 1'b1; size_s = 2'd1; end
      4'b1010: begin is_store_s = 1'b1; size_s = 2'd2; end
      default: begin is_load_s = 1'b0; is_store_s = 1'b0; end
    endcase
    is_mem_s     = is_load_s | is_store_s;
    misaligned_s = ((size_s == 2'd1) && mem_addr_i[0]) ||
                   ((size_s == 2'd2) && (mem_addr_i[1:0] != 2'b00));
  end

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    lane_sel_s   = 4'b1111;
    lane_wdata_s = mem_sdata_i;
    case (size_s)
      2'd0: begin
        lane_sel_s   = 4'b0001 << mem_addr_i[1:0];
        lane_wdata_s = {4{mem_sdata_i[7:0]}};
      end
      2'd1: begin
        lane_sel_s   = 4'b0011 << mem_addr_i[1:0];
        lane_wdata_s = {2{mem_sdata_i[15:0]}};
      end
      default: begin
        lane_sel_s   = 4'b1111;
        lane_wdata_s = mem_sdata_i;
      end
    endcase
  end

  // Load extraction; EX/MEM inputs are frozen during the access so addr/memop are still valid here
  always_comb begin
    shifted_s = rdata_q >> {mem_addr_i[1:0], 3'b000};
    load_s    = shifted_s;
    case (size_s)
      2'd0: load_s = is_unsigned_s ? {24'd0, shifted_s[7:0]}
                                   : {{24{shifted_s[7]}}, shifted_s[7:0]};
      2'd1: load_s = is_unsigned_s ? {16'd0, shifted_s[15:0]}
                                   : {{16{shifted_s[15]}}, shifted_s[15:0]};
      default: load_s = shifted_s;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;

  assign limit_s = (cnt_q == CW'(TIMEOUT - 1));

  // Wait counter: held clear outside BUSY, counts BUSY cycles without ack
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY) begin
      cnt_d = {CW{1'b0}};
    end else if (!dbus_ack_i) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT != 0);
  assign limit_s          = 1'b0;
`endif

  // FSM next state, bus register loads and writeback outputs
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    stall_s = 1'b0;
    wreg_s  = wreg_i;
    wdata_s = wdata_i;
    err_s   = 1'b0;
    case (state_q)
      IDLE: begin
        to_d = 1'b0;
        if (is_mem_s && misaligned_s) begin
          err_s  = 1'b1;
          wreg_s = 1'b0;
        end else if (is_mem_s) begin
          stall_s = 1'b1;
          wreg_s  = 1'b0;
          addr_d  = {mem_addr_i[31:2], 2'b00};
          we_d    = is_store_s;
          sel_d   = lane_sel_s;
          wdata_d = lane_wdata_s;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        wreg_s  = 1'b0;
        if (dbus_ack_i) begin
          rdata_d = dbus_rdata_i;
          state_d = DONE;
        end else if (limit_s) begin
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (to_q) begin
          err_s   = 1'b1;
          wreg_s  = 1'b0;
          wdata_s = 32'd0;
        end else if (is_load_s) begin
          wreg_s  = wreg_i;
          wdata_s = load_s;
        end else begin
          wreg_s  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bus-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      to_q    <= to_d;
    end
  end

  // Combinational outputs are gated so everything reads 0 while reset is held
  assign dbus_req_o   = ~rst & (state_q == BUSY);
  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_sel_o   = sel_q;
  assign dbus_wdata_o = wdata_q;
  assign stall_req_o  = ~rst & stall_s;
  assign wd_o         = rst ? 5'd0 : wd_i;
  assign wreg_o       = ~rst & wreg_s;
  assign wdata_o      = rst ? 32'd0 : wdata_s;
  assign err_o        = ~rst & err_s;

endmodule
